// File: rtl/lcd_frame_writer_if.sv
// PPU-side pixel stream and frame-buffer write port of the LCD frame writer.
// The slave modport is the writer; the master modport is whatever drives the pixel stream.
interface lcd_frame_writer_if;
  logic [1:0]  pixel_in;
  logic        pixel_valid_in;
  logic        hblank_in;
  logic        vblank_in;
  logic        lcd_on_in;
  logic [15:0] wr_addr_out;
  logic [1:0]  wr_data_out;
  logic        wr_en_out;
  logic        disp_bank_out;
  logic        frame_done_out;
  logic        error_out;
  logic [7:0]  x_out;
  logic [7:0]  y_out;

  modport master (
    output pixel_in, pixel_valid_in, hblank_in, vblank_in, lcd_on_in,
    input  wr_addr_out, wr_data_out, wr_en_out, disp_bank_out, frame_done_out, error_out,
    input  x_out, y_out
  );

  modport slave (
    input  pixel_in, pixel_valid_in, hblank_in, vblank_in, lcd_on_in,
    output wr_addr_out, wr_data_out, wr_en_out, disp_bank_out, frame_done_out, error_out,
    output x_out, y_out
  );
endinterface

// File: rtl/lcd_frame_writer.sv
// Writes the PPU pixel stream into the back bank of a double-buffered frame store,
// swapping banks at VBlank and zero-filling the back bank when the LCD is switched off.
module lcd_frame_writer #(
  parameter int unsigned LCD_W     = 160,
  parameter int unsigned LCD_H     = 144,
  parameter int unsigned BANK_SIZE = LCD_W * LCD_H
) (
  input logic               clk_in,
  input logic               rst_in,
  lcd_frame_writer_if.slave bus
);

  localparam logic [7:0]  XEnd     = 8'(LCD_W);
  localparam logic [7:0]  YEnd     = 8'(LCD_H);
  localparam logic [15:0] LineStep = 16'(LCD_W);
  localparam logic [15:0] BankBase = 16'(BANK_SIZE);
  localparam logic [15:0] ClrLast  = 16'(BANK_SIZE - 1);

  typedef enum logic [2:0] {StSync, StDraw, StHbl, StVbl, StClear, StOff} state_e;

  state_e      state_q, state_d;
  logic [7:0]  x_q, x_d, y_q, y_d;
  logic [15:0] line_base_q, line_base_d;
  logic [15:0] clr_cnt_q, clr_cnt_d;
  logic        hblank_q, vblank_q, lcd_on_q;
  logic        wr_en_q, wr_en_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [1:0]  wr_data_q, wr_data_d;
  logic        disp_bank_q, disp_bank_d;
  logic        frame_done_q, frame_done_d;
  logic        error_q, error_d;

  logic        hb_rise, hb_fall, vb_rise, vb_fall, lcd_fall, swap;
  logic [15:0] back_base;

  assign hb_rise   = bus.hblank_in & ~hblank_q;
  assign hb_fall   = ~bus.hblank_in & hblank_q;
  assign vb_rise   = bus.vblank_in & ~vblank_q;
  assign vb_fall   = ~bus.vblank_in & vblank_q;
  assign lcd_fall  = ~bus.lcd_on_in & lcd_on_q;
  assign back_base = disp_bank_q ? 16'd0 : BankBase;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    line_base_d  = line_base_q;
    clr_cnt_d    = clr_cnt_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    disp_bank_d  = disp_bank_q;
    frame_done_d = 1'b0;
    error_d      = error_q;
    swap         = 1'b0;

    if (lcd_fall) begin
      state_d   = StClear;
      clr_cnt_d = 16'd0;
    end else begin
      unique case (state_q)
        StSync, StVbl: begin
          if (state_q == StVbl && bus.pixel_valid_in) error_d = 1'b1;
          if (vb_fall) begin
            state_d     = StDraw;
            x_d         = 8'd0;
            y_d         = 8'd0;
            line_base_d = 16'd0;
          end
        end
        StDraw: begin
          if (bus.pixel_valid_in) begin
            if (x_q < XEnd) begin
              wr_en_d   = 1'b1;
              wr_addr_d = back_base + line_base_q + {8'd0, x_q};
              wr_data_d = bus.pixel_in;
              x_d       = x_q + 8'd1;
            end else begin
              error_d = 1'b1;
            end
          end
          if (vb_rise) begin
            if (y_q != YEnd) error_d = 1'b1;
            swap    = 1'b1;
            state_d = StVbl;
          end else if (hb_rise) begin
            // x_d already includes a pixel arriving on the same cycle as the edge
            if (x_d != XEnd) error_d = 1'b1;
            x_d         = 8'd0;
            y_d         = (y_q < YEnd) ? y_q + 8'd1 : y_q;
            line_base_d = line_base_q + LineStep;
            state_d     = StHbl;
          end
        end
        StHbl: begin
          if (bus.pixel_valid_in) error_d = 1'b1;
          if (vb_rise) begin
            if (y_q != YEnd) error_d = 1'b1;
            swap    = 1'b1;
            state_d = StVbl;
          end else if (hb_fall && y_q < YEnd) begin
            state_d = StDraw;
          end
        end
        StClear: begin
          wr_en_d   = 1'b1;
          wr_addr_d = back_base + clr_cnt_q;
          wr_data_d = 2'd0;
          if (clr_cnt_q == ClrLast) begin
            swap    = 1'b1;
            state_d = bus.lcd_on_in ? StSync : StOff;
          end else begin
            clr_cnt_d = clr_cnt_q + 16'd1;
          end
        end
        StOff: begin
          if (bus.lcd_on_in) state_d = StSync;
        end
        default: state_d = StSync;
      endcase
    end

    if (swap) begin
      disp_bank_d  = ~disp_bank_q;
      frame_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= StSync;
      x_q          <= 8'd0;
      y_q          <= 8'd0;
      line_base_q  <= 16'd0;
      clr_cnt_q    <= 16'd0;
      hblank_q     <= 1'b0;
      vblank_q     <= 1'b0;
      lcd_on_q     <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 16'd0;
      wr_data_q    <= 2'd0;
      disp_bank_q  <= 1'b0;
      frame_done_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      line_base_q  <= line_base_d;
      clr_cnt_q    <= clr_cnt_d;
      hblank_q     <= bus.hblank_in;
      vblank_q     <= bus.vblank_in;
      lcd_on_q     <= bus.lcd_on_in;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      disp_bank_q  <= disp_bank_d;
      frame_done_q <= frame_done_d;
      error_q      <= error_d;
    end
  end

  assign bus.wr_en_out      = wr_en_q;
  assign bus.wr_addr_out    = wr_addr_q;
  assign bus.wr_data_out    = wr_data_q;
  assign bus.disp_bank_out  = disp_bank_q;
  assign bus.frame_done_out = frame_done_q;
  assign bus.error_out      = error_q;
  assign bus.x_out          = x_q;
  assign bus.y_out          = y_q;

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Random pixel-stream bench for lcd_frame_writer: the stimulus tasks predict every write,
// bank swap and error from screen coordinates, and each cycle the outputs are checked.
module tb_lcd_frame_writer;
  localparam int W    = 160;
  localparam int H    = 144;
  localparam int BANK = W * H;

  logic clk = 1'b0;
  logic rst;

  lcd_frame_writer_if bus ();

  lcd_frame_writer #(
    .LCD_W    (W),
    .LCD_H    (H),
    .BANK_SIZE(BANK)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int when;
    int addr;
    int data;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  int  cyc = 0, n_chk = 0, n_err = 0, err_at = 0;
  int  wr_cnt = 0, snap = 0, first_addr = 0, last_addr = 0, done_cnt = 0, d0 = 0;
  bit  model_bank = 1'b0, exp_bank = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare();
    int exp_done = 0;
    while (wq.size() > 0 && wq[0].when < cyc) begin
      chk("wr_missing", 0, 1);
      void'(wq.pop_front());
    end
    if (wq.size() > 0 && wq[0].when == cyc) begin
      chk("wr_en", int'(bus.wr_en_out), 1);
      chk("wr_addr", int'(bus.wr_addr_out), wq[0].addr);
      chk("wr_data", int'(bus.wr_data_out), wq[0].data);
      void'(wq.pop_front());
    end else begin
      chk("wr_idle", int'(bus.wr_en_out), 0);
    end
    if (bus.wr_en_out) begin
      wr_cnt++;
      if (wr_cnt == snap + 1) first_addr = int'(bus.wr_addr_out);
      last_addr = int'(bus.wr_addr_out);
    end
    if (dq.size() > 0 && dq[0] == cyc) begin
      exp_done = 1;
      void'(dq.pop_front());
      exp_bank = ~exp_bank;
    end
    if (bus.frame_done_out) done_cnt++;
    chk("frame_done", int'(bus.frame_done_out), exp_done);
    chk("disp_bank", int'(bus.disp_bank_out), int'(exp_bank));
    chk("error_out", int'(bus.error_out), int'(err_at != 0 && cyc >= err_at));
    if (n_err >= 100) begin
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    compare();
  endtask

  task automatic flag_err();
    if (err_at == 0) err_at = cyc + 1;
  endtask

  task automatic accept(input int l, input int x, input logic [1:0] d);
    if (x < W) wq.push_back('{cyc + 1, (model_bank ? 0 : BANK) + l * W + x, int'(d)});
    else flag_err();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    wq.delete();
    dq.delete();
    err_at     = 0;
    model_bank = 1'b0;
    exp_bank   = 1'b0;
    chk("rst_wr_en", int'(bus.wr_en_out), 0);
    chk("rst_wr_addr", int'(bus.wr_addr_out), 0);
    chk("rst_wr_data", int'(bus.wr_data_out), 0);
    chk("rst_disp_bank", int'(bus.disp_bank_out), 0);
    chk("rst_frame_done", int'(bus.frame_done_out), 0);
    chk("rst_error", int'(bus.error_out), 0);
    chk("rst_xy", int'({bus.x_out, bus.y_out}), 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // vblank pulse; optional junk pixels while the writer is still unsynchronised
  task automatic start_frame(input bit noise);
    bus.vblank_in = 1'b1;
    repeat (4) begin
      if (noise) begin
        bus.pixel_valid_in = 1'($urandom_range(1));
        bus.pixel_in       = 2'($urandom_range(3));
      end
      tick();
    end
    bus.pixel_valid_in = 1'b0;
    bus.vblank_in      = 1'b0;
    tick();
  endtask

  task automatic draw_pixels(input int l, input int x0, input int n);
    logic [1:0] d;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(15) == 0) tick();
      d = 2'($urandom_range(3));
      bus.pixel_in       = d;
      bus.pixel_valid_in = 1'b1;
      accept(l, x0 + i, d);
      tick();
      bus.pixel_valid_in = 1'b0;
    end
  endtask

  task automatic end_line(input int l, input int nx, input bit coincide, input bit hbl_pix);
    logic [1:0] d;
    int         acc;
    bit         junk;
    acc           = nx;
    junk          = hbl_pix;
    bus.hblank_in = 1'b1;
    if (coincide) begin
      d = 2'($urandom_range(3));
      bus.pixel_in       = d;
      bus.pixel_valid_in = 1'b1;
      accept(l, acc, d);
      acc++;
    end
    if (acc < W) flag_err();
    tick();
    bus.pixel_valid_in = 1'b0;
    repeat (1 + $urandom_range(2)) begin
      if (junk) begin
        bus.pixel_in       = 2'($urandom_range(3));
        bus.pixel_valid_in = 1'b1;
        flag_err();
        junk = 1'b0;
      end
      tick();
      bus.pixel_valid_in = 1'b0;
    end
    bus.hblank_in = 1'b0;
    tick();
  endtask

  task automatic draw_line(input int l, input int n, input bit coincide, input bit hbl_pix);
    int m;
    m = coincide ? n - 1 : n;
    draw_pixels(l, 0, m);
    end_line(l, m, coincide, hbl_pix);
  endtask

  task automatic end_frame(input int lines, input bit vbl_pix);
    bus.vblank_in = 1'b1;
    if (lines != H) flag_err();
    dq.push_back(cyc + 1);
    model_bank = ~model_bank;
    tick();
    if (vbl_pix) begin
      bus.pixel_in       = 2'($urandom_range(3));
      bus.pixel_valid_in = 1'b1;
      flag_err();
      tick();
      bus.pixel_valid_in = 1'b0;
    end
    repeat (2) tick();
  endtask

  // Zero-fill of the back bank: word k lands two cycles after the drop plus k
  task automatic lcd_drop();
    bus.lcd_on_in      = 1'b0;
    bus.pixel_valid_in = 1'b0;
    for (int k = 0; k < BANK; k++) wq.push_back('{cyc + 2 + k, (model_bank ? 0 : BANK) + k, 0});
    dq.push_back(cyc + 2 + BANK - 1);
    model_bank = ~model_bank;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                = 1'b0;
    bus.pixel_in       = 2'd0;
    bus.pixel_valid_in = 1'b0;
    bus.hblank_in      = 1'b0;
    bus.vblank_in      = 1'b0;
    bus.lcd_on_in      = 1'b1;
    #2;
    do_reset();

    // Full frame into bank 1, then a stray pixel in VBlank
    start_frame(1'b1);
    snap = wr_cnt;
    d0   = done_cnt;
    for (int l = 0; l < H; l++) draw_line(l, W, 1'($urandom_range(1)), 1'b0);
    chk("frame1_y_clamp", int'(bus.y_out), H);
    chk("frame1_x", int'(bus.x_out), 0);
    end_frame(H, 1'b0);
    chk("frame1_writes", wr_cnt - snap, BANK);
    chk("frame1_first", first_addr, BANK);
    chk("frame1_last", last_addr, 2 * BANK - 1);
    chk("frame1_done_cnt", done_cnt - d0, 1);
    chk("frame1_bank", int'(bus.disp_bank_out), 1);
    chk("frame1_error", int'(bus.error_out), 0);
    bus.pixel_in       = 2'd3;
    bus.pixel_valid_in = 1'b1;
    flag_err();
    tick();
    bus.pixel_valid_in = 1'b0;
    tick();
    chk("vbl_pixel_err", int'(bus.error_out), 1);
    start_frame(1'b0);
    snap = wr_cnt;
    draw_pixels(0, 0, W);
    tick();
    chk("frame2_first", first_addr, 0);
    chk("frame2_line0_cnt", wr_cnt - snap, W);

    // Short line
    do_reset();
    start_frame(1'b0);
    draw_line(0, W - 1, 1'b0, 1'b0);
    chk("short_line_err", int'(bus.error_out), 1);
    snap = wr_cnt;
    draw_pixels(1, 0, 4);
    tick();
    chk("after_short_base", first_addr, BANK + W);

    // 161st pixel
    do_reset();
    start_frame(1'b0);
    snap = wr_cnt;
    draw_pixels(0, 0, W + 1);
    tick();
    chk("long_line_x_clamp", int'(bus.x_out), W);
    chk("long_line_err", int'(bus.error_out), 1);
    chk("long_line_writes", wr_cnt - snap, W);

    // Early VBlank
    do_reset();
    start_frame(1'b0);
    draw_line(0, W, 1'b1, 1'b0);
    chk("one_line_y", int'(bus.y_out), 1);
    end_frame(1, 1'b0);
    chk("early_vbl_err", int'(bus.error_out), 1);
    chk("early_vbl_bank", int'(bus.disp_bank_out), 1);

    // Pixel inside HBlank
    do_reset();
    start_frame(1'b0);
    draw_line(0, W, 1'b0, 1'b1);
    chk("hbl_pixel_err", int'(bus.error_out), 1);

    // LCD off mid-frame: full clear then OFF
    do_reset();
    start_frame(1'b0);
    for (int l = 0; l < 3; l++) draw_line(l, W, 1'b0, 1'b0);
    draw_pixels(3, 0, 50);
    snap = wr_cnt;
    d0   = done_cnt;
    lcd_drop();
    repeat (BANK + 4) tick();
    chk("clear_writes", wr_cnt - snap, BANK);
    chk("clear_first", first_addr, BANK);
    chk("clear_last", last_addr, 2 * BANK - 1);
    chk("clear_done_cnt", done_cnt - d0, 1);
    chk("clear_bank", int'(bus.disp_bank_out), 1);
    chk("clear_error", int'(bus.error_out), 0);
    snap = wr_cnt;
    repeat (40) tick();
    chk("off_no_writes", wr_cnt - snap, 0);
    bus.lcd_on_in = 1'b1;
    repeat (2) tick();
    start_frame(1'b0);
    snap = wr_cnt;
    draw_pixels(0, 0, 5);
    tick();
    chk("resume_first", first_addr, 0);

    // LCD back on during the clear must not shorten it
    snap = wr_cnt;
    lcd_drop();
    repeat (300) tick();
    bus.lcd_on_in = 1'b1;
    repeat (BANK) tick();
    chk("clear2_writes", wr_cnt - snap, BANK);
    chk("clear2_first", first_addr, 0);
    chk("clear2_bank", int'(bus.disp_bank_out), 0);
    start_frame(1'b0);
    snap = wr_cnt;
    draw_pixels(0, 0, 3);
    tick();
    chk("clear2_resync", first_addr, BANK);

    // Reset partway through a clear
    do_reset();
    start_frame(1'b0);
    draw_pixels(0, 0, 10);
    tick();
    snap = wr_cnt;
    lcd_drop();
    repeat (101) tick();
    chk("clear_progress", wr_cnt - snap, 100);
    do_reset();
    snap = wr_cnt;
    repeat (20) tick();
    chk("post_rst_no_writes", wr_cnt - snap, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
